// File: rtl/ctrl_sequencer.sv
// Multi-cycle control unit for the 16-bit CPU datapath: latches an instruction
// from DIN and steps T0..T3 to drive register-file, A/G and bus-mux enables.
module ctrl_sequencer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREG  = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             Run,
    input  logic [WIDTH-1:0] DIN,
    output logic [WIDTH-1:0] IR,
    output logic [NREG-1:0]  Rin,
    output logic [NREG-1:0]  Rout,
    output logic             Ain,
    output logic             Gin,
    output logic             Gout,
    output logic             DINout,
    output logic             AddSub,
    output logic             Done
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } tstep_e;

    typedef enum logic [3:0] {
        OP_MV  = 4'd0,
        OP_MVI = 4'd1,
        OP_ADD = 4'd2,
        OP_SUB = 4'd3
    } opcode_e;

    tstep_e           tstep_q, tstep_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic             ir_in;
    logic [3:0]       op;
    logic [2:0]       rx;
    logic [2:0]       ry;

    assign op = ir_q[15:12];
    assign rx = ir_q[11:9];
    assign ry = ir_q[8:6];
    assign IR = ir_q;

    // Indices at or above NREG select nothing, so a narrow register file
    // never sees a stray enable.
    function automatic logic [NREG-1:0] reg_sel(input logic [2:0] idx);
        logic [NREG-1:0] sel;
        sel = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if ({29'd0, idx} == i) begin
                sel[i] = 1'b1;
            end
        end
        return sel;
    endfunction

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            tstep_q <= T0;
            ir_q    <= '0;
        end else begin
            tstep_q <= tstep_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        ir_in   = 1'b0;
        Rin     = '0;
        Rout    = '0;
        Ain     = 1'b0;
        Gin     = 1'b0;
        Gout    = 1'b0;
        DINout  = 1'b0;
        AddSub  = 1'b0;
        Done    = 1'b0;
        tstep_d = tstep_q;
        ir_d    = ir_q;

        case (tstep_q)
            T0: begin
                ir_in = Run;
                if (Run) begin
                    tstep_d = T1;
                end
            end
            T1: begin
                case (op)
                    OP_MV: begin
                        Rout = reg_sel(ry);
                        Rin  = reg_sel(rx);
                        Done = 1'b1;
                    end
                    OP_MVI: begin
                        DINout = 1'b1;
                        Rin    = reg_sel(rx);
                        Done   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        Rout = reg_sel(rx);
                        Ain  = 1'b1;
                    end
                    default: begin
                        Done = 1'b1;
                    end
                endcase
            end
            T2: begin
                if (op == OP_ADD || op == OP_SUB) begin
                    Rout   = reg_sel(ry);
                    Gin    = 1'b1;
                    AddSub = (op == OP_SUB);
                end
            end
            T3: begin
                Gout = 1'b1;
                Rin  = reg_sel(rx);
                Done = 1'b1;
            end
            default: begin
            end
        endcase

        if (ir_in) begin
            ir_d = DIN;
        end

        // Steps T1..T3 advance until the instruction signals Done.
        if (tstep_q != T0) begin
            tstep_d = Done ? T0 : tstep_e'(tstep_q + 2'd1);
        end
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Randomised and directed bench for ctrl_sequencer, checked every cycle
// against an instruction-level model of the control sequence.
module tb_ctrl_sequencer;

    logic        clk;
    logic        clr;
    logic        Run;
    logic [15:0] DIN;
    logic [15:0] IR;
    logic [7:0]  Rin;
    logic [7:0]  Rout;
    logic        Ain;
    logic        Gin;
    logic        Gout;
    logic        DINout;
    logic        AddSub;
    logic        Done;

    int n_checks = 0;
    int n_fail   = 0;

    ctrl_sequencer #(.WIDTH(16), .NREG(8)) dut (
        .clk    (clk),
        .clr    (clr),
        .Run    (Run),
        .DIN    (DIN),
        .IR     (IR),
        .Rin    (Rin),
        .Rout   (Rout),
        .Ain    (Ain),
        .Gin    (Gin),
        .Gout   (Gout),
        .DINout (DINout),
        .AddSub (AddSub),
        .Done   (Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: position within the current instruction (0 = waiting in T0)
    // and the instruction being executed.
    int          m_pos;
    logic [15:0] m_ir;

    function automatic int instr_len(input logic [15:0] ins);
        return (ins[15:12] == 4'd2 || ins[15:12] == 4'd3) ? 4 : 2;
    endfunction

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            m_pos = 0;
            m_ir  = 16'h0000;
        end else if (m_pos == 0) begin
            if (Run) begin
                m_ir  = DIN;
                m_pos = 1;
            end
        end else if (m_pos == instr_len(m_ir) - 1) begin
            m_pos = 0;
        end else begin
            m_pos = m_pos + 1;
        end
    end

    always @(negedge clk) begin
        logic [3:0] op;
        logic [7:0] e_rin, e_rout, x_rx, x_ry;
        logic       e_ain, e_gin, e_gout, e_dinout, e_addsub, e_done;
        int         drivers;
        op       = m_ir[15:12];
        x_rx     = 8'd1 << m_ir[11:9];
        x_ry     = 8'd1 << m_ir[8:6];
        e_rin    = 8'h00;
        e_rout   = 8'h00;
        e_ain    = 1'b0;
        e_gin    = 1'b0;
        e_gout   = 1'b0;
        e_dinout = 1'b0;
        e_addsub = 1'b0;
        e_done   = (m_pos != 0) && (m_pos == instr_len(m_ir) - 1);
        if (op == 4'd0 && m_pos == 1) begin
            e_rout = x_ry;
            e_rin  = x_rx;
        end
        if (op == 4'd1 && m_pos == 1) begin
            e_dinout = 1'b1;
            e_rin    = x_rx;
        end
        if (op == 4'd2 || op == 4'd3) begin
            if (m_pos == 1) begin
                e_rout = x_rx;
                e_ain  = 1'b1;
            end
            if (m_pos == 2) begin
                e_rout   = x_ry;
                e_gin    = 1'b1;
                e_addsub = (op == 4'd3);
            end
            if (m_pos == 3) begin
                e_gout = 1'b1;
                e_rin  = x_rx;
            end
        end
        chk("IR", IR, m_ir);
        chk("Rin", Rin, e_rin);
        chk("Rout", Rout, e_rout);
        chk("Ain", Ain, e_ain);
        chk("Gin", Gin, e_gin);
        chk("Gout", Gout, e_gout);
        chk("DINout", DINout, e_dinout);
        chk("AddSub", AddSub, e_addsub);
        chk("Done", Done, e_done);
        drivers = ((Rout != 8'h00) ? 1 : 0) + (Gout ? 1 : 0) + (DINout ? 1 : 0);
        chk("bus_single_driver", (drivers <= 1), 1);
        chk("Rin_onehot0", $onehot0(Rin), 1);
        chk("Rout_onehot0", $onehot0(Rout), 1);
    end

    task automatic step(input logic run, input logic [15:0] din);
        Run = run;
        DIN = din;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_IR"}, IR, 16'h0000);
        chk({name, "_en"}, {Rin, Rout, Ain, Gin, Gout, DINout, AddSub, Done}, 0);
    endtask

    initial begin
        clr = 1'b1;
        Run = 1'b0;
        DIN = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        clr = 1'b0;
        step(1'b0, 16'h1234);
        step(1'b0, 16'h2680);
        chk_all_zero("idle_after_reset");

        step(1'b1, 16'h1000);
        chk("mvi_IR", IR, 16'h1000);
        chk("mvi_T1", {DINout, Rin, Done}, {1'b1, 8'h01, 1'b1});
        step(1'b0, 16'h00A5);
        chk("mvi_T0_after", {DINout, Rin, Rout, Done}, 0);

        step(1'b1, 16'h0280);
        chk("mv_T1", {Rout, Rin, Done, DINout}, {8'h04, 8'h02, 1'b1, 1'b0});
        step(1'b0, 16'h0000);
        chk("mv_T0_after", {Rout, Rin, Done}, 0);

        step(1'b1, 16'h2680);
        chk("add_T1", {Rout, Ain, Done}, {8'h08, 1'b1, 1'b0});
        step(1'b0, 16'h0000);
        chk("add_T2", {Rout, Gin, AddSub, Done}, {8'h04, 1'b1, 1'b0, 1'b0});
        step(1'b0, 16'h0000);
        chk("add_T3", {Gout, Rin, Done, Rout}, {1'b1, 8'h08, 1'b1, 8'h00});
        step(1'b0, 16'h0000);
        chk("add_T0_after", {Gout, Rin, Done}, 0);

        step(1'b1, 16'h3240);
        chk("sub_T1", {Rout, Ain, AddSub}, {8'h02, 1'b1, 1'b0});
        step(1'b0, 16'hFFFF);
        chk("sub_T2", {Rout, Gin, AddSub}, {8'h02, 1'b1, 1'b1});
        step(1'b0, 16'hFFFF);
        chk("sub_T3", {Gout, Rin, Done, AddSub}, {1'b1, 8'h02, 1'b1, 1'b0});
        step(1'b0, 16'hFFFF);
        step(1'b0, 16'hFFFF);
        chk("sub_hold_T0", {Done, IR}, {1'b0, 16'h3240});

        step(1'b1, 16'hF000);
        chk("nop_T1", {Done, Rin, Rout, DINout, Gout}, {1'b1, 8'h00, 8'h00, 1'b0, 1'b0});
        step(1'b1, 16'h1E00);
        chk("b2b_T0", Done, 1'b0);
        step(1'b1, 16'h1E00);
        chk("b2b_IR", IR, 16'h1E00);
        chk("b2b_mvi_T1", {DINout, Rin, Done}, {1'b1, 8'h80, 1'b1});

        step(1'b0, 16'h0000);
        step(1'b1, 16'h2680);
        step(1'b0, 16'h0000);
        chk("clr_pre_T2", Gin, 1'b1);
        #2 clr = 1'b1;
        #1 chk_all_zero("async_clr");
        @(negedge clk);
        #1 clr = 1'b0;
        step(1'b0, 16'h2680);
        step(1'b0, 16'h2680);
        chk_all_zero("clr_release_idle");

        for (int i = 0; i < 400; i++) begin
            logic [3:0] op;
            op = ($urandom_range(7) < 6) ? 4'($urandom_range(3)) : 4'($urandom_range(15, 4));
            step(1'($urandom_range(1)), {op, 12'($urandom)});
            if ($urandom_range(39) == 0) begin
                #2 clr = 1'b1;
                #1 chk_all_zero("rand_async_clr");
                #1 clr = 1'b0;
            end
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
Multi-cycle control unit for the 16-bit CPU datapath. It latches an instruction from the DIN bus and uses a 2-bit internal timestep counter (T0–T3) to sequence bus transfers. Each step drives the register-file, A/G and bus-mux enables. It sits downstream of the step-counter/instruction source and upstream of the register file, ALU and bus mux.

Parameters:
WIDTH, 16, data/instruction bus width (must be 16; the IR field positions are fixed)
NREG, 8, number of general registers; width of the Rin/Rout one-hot vectors

Ports:
clk  in  1  system clock, rising-edge active
clr  in  1  asynchronous active-high reset
Run  in  1  start request, sampled in T0
DIN  in  WIDTH  instruction/immediate bus from memory/switches
IR  out  WIDTH  latched instruction register
Rin  out  NREG  one-hot register load enables
Rout  out  NREG  one-hot register bus-drive enables
Ain  out  1  load ALU A operand register
Gin  out  1  load ALU result register G
Gout  out  1  G drives bus
DINout  out  1  DIN drives bus
AddSub  out  1  ALU op: 0 = add, 1 = subtract
Done  out  1  final step of the current instruction

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (clk, clr). While clr=1: Tstep=T0 and IR=0. All outputs are 0 except IRin, which is internal; see below.
- IR field decode: op=IR[15:12], rx=IR[11:9], ry=IR[8:6]. IR[5:0] is ignored.
- Opcodes: 0 = mv rx,ry; 1 = mvi rx,#D; 2 = add rx,ry; 3 = sub rx,ry; 4–15 = NOP.
- Registered state: Tstep (2-bit) and IR only. All control outputs are combinational from Tstep, IR and Run.
- Tstep transitions:
  - T0→T1 iff Run=1; otherwise stay in T0.
  - In T1–T3: if Done=1, next step is T0; otherwise Tstep+1.
  - Run is ignored outside T0. Deasserting Run mid-instruction does not abort.
- T0: internal IRin = Run. IR <= DIN on the edge where IRin=1. No bus enables asserted.
- mv: T1 asserts Rout[ry], Rin[rx], Done.
- mvi: T1 asserts DINout, Rin[rx], Done. The immediate must be on DIN during T1.
- add/sub:
  - T1: Rout[rx], Ain.
  - T2: Rout[ry], Gin, AddSub = (op==3).
  - T3: Gout, Rin[rx], Done.
- NOP: T1 asserts Done only.
- Instruction latency: mv/mvi/NOP take 2 cycles including T0; add/sub take 4.
- Invariants:
  - At most one of {Rout[*], Gout, DINout} is nonzero in any cycle (single bus driver).
  - Rin and Rout each have at most one bit set.
  - Done is 1 for exactly one cycle per instruction.
- rx==ry is legal: add R2,R2 doubles R2; mv R3,R3 is a no-op write.
- AddSub is 0 in every step other than T2 of sub.
- clr mid-instruction: Tstep→T0 and IR→0 immediately, with no clock edge needed. All enables drop in the same cycle, and the partial instruction is abandoned.
- Back-to-back: with Run held at 1, T0 follows every Done and a new IR is latched.
- NREG generalisation: if NREG<8, register indices ≥NREG produce all-zero Rin/Rout.

Test Plan:
- Reset: assert clr async mid-cycle during T2 of add -> IR=0, Tstep=T0 and all outputs 0 before the next edge. Release clr with Run=0 -> stays in T0.
- mvi: DIN=0x1000 (mvi R0), Run=1 for one cycle, then DIN=0x00A5 -> T1: DINout=1, Rin=0x01, Done=1. Next cycle T0 with all enables 0.
- mv: DIN=0x0280 (mv R1,R2) -> T1: Rout=0x04, Rin=0x02, Done=1. Total 2 cycles.
- add: DIN=0x2680 (add R3,R2):
  - T1: Rout=0x08, Ain=1.
  - T2: Rout=0x04, Gin=1, AddSub=0.
  - T3: Gout=1, Rin=0x08, Done=1.
- sub with Run dropped at T1: DIN=0x3240 (sub R1,R1), Run=0 after T0 -> sequence completes, AddSub=1 only in T2. Returns to and holds T0.
- NOP and back-to-back: DIN=0xF000 then 0x1E00 with Run held at 1 -> Done in T1 of the NOP, T0 latches 0x1E00, its T1 asserts DINout and Rin=0x80. Bus-exclusivity assertion holds across the whole run.
